// File: rtl/avalon_crypto_ctrl.sv
// Avalon-MM control block for a crypto engine: key/message/result register
// file, CTRL/STATUS registers, and a launch/wait FSM with a cycle timeout.
//
// Bus handshake: zero-wait-state slave. A write is accepted in every cycle
// where AVL_CS & AVL_WRITE is high. A read is accepted in every cycle where
// AVL_CS & AVL_READ is high. AVL_READDATA carries the addressed word from the
// cycle after the read and holds it until the next read.
module avalon_crypto_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 4,
  parameter int NUM_KEY     = 4,
  parameter int NUM_MSG     = 4,
  parameter int NUM_OUT     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       AVL_CS,
  input  logic                       AVL_READ,
  input  logic                       AVL_WRITE,
  input  logic [ADDR_W-1:0]          AVL_ADDR,
  input  logic [DATA_W/8-1:0]        AVL_BYTE_EN,
  input  logic [DATA_W-1:0]          AVL_WRITEDATA,
  output logic [DATA_W-1:0]          AVL_READDATA,
  output logic [NUM_KEY*DATA_W-1:0]  ENG_KEY,
  output logic [NUM_MSG*DATA_W-1:0]  ENG_MSG,
  output logic                       ENG_START,
  input  logic                       ENG_DONE,
  input  logic [NUM_OUT*DATA_W-1:0]  ENG_RESULT,
  output logic [DATA_W-1:0]          EXPORT_DATA,
  output logic [1:0]                 dbg_state
);

  localparam int NB        = DATA_W / 8;
  localparam int MAP_WORDS = 2 ** ADDR_W;
  localparam int MSG_BASE  = NUM_KEY;
  localparam int OUT_BASE  = NUM_KEY + NUM_MSG;
  localparam int CTRL_ADDR = MAP_WORDS - 2;
  localparam int STAT_ADDR = MAP_WORDS - 1;
  localparam int CNT_W     = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  // Reject parameter sets the register map cannot hold.
  if (NUM_KEY + NUM_MSG + NUM_OUT > MAP_WORDS - 2) begin : g_bad_map
    $error("avalon_crypto_ctrl: KEY+MSG+OUT words exceed the register map");
  end
  if ((DATA_W % 8) != 0 || DATA_W < 16 || DATA_W > 64) begin : g_bad_width
    $error("avalon_crypto_ctrl: DATA_W must be a multiple of 8 in 16..64");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("avalon_crypto_ctrl: TIMEOUT_CYC must be at least 2");
  end

  logic [1:0]                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [NUM_KEY*DATA_W-1:0] key_q, key_d;
  logic [NUM_MSG*DATA_W-1:0] msg_q, msg_d;
  logic [NUM_OUT*DATA_W-1:0] res_q, res_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic [7:0]                sel_q, sel_d;
  logic [DATA_W-1:0]         rdata_q, rdata_d;

  logic                      wr_en, rd_en, busy, ctrl_wr, start_req, clr_req;
  logic [DATA_W-1:0]         map_w [MAP_WORDS];
  logic [ADDR_W-1:0]         sel_idx;

  // Byte-lane merge of a bus write into an existing word.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [NB-1:0]     be
  );
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < NB; b++) begin
      if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return r;
  endfunction

  assign wr_en     = AVL_CS & AVL_WRITE;
  assign rd_en     = AVL_CS & AVL_READ;
  assign busy      = (state_q != ST_IDLE);
  assign ctrl_wr   = wr_en && (AVL_ADDR == ADDR_W'(CTRL_ADDR));
  // START and CLR_ERR live in byte 0, so they only act when that lane is enabled.
  assign start_req = ctrl_wr && AVL_BYTE_EN[0] && AVL_WRITEDATA[0];
  assign clr_req   = ctrl_wr && AVL_BYTE_EN[0] && AVL_WRITEDATA[1];

  // Key/message/export-select register updates from the bus.
  always_comb begin
    key_d = key_q;
    msg_d = msg_q;
    sel_d = sel_q;
    // Operands are frozen while the engine is running.
    if (wr_en && !busy) begin
      for (int i = 0; i < NUM_KEY; i++) begin
        if (AVL_ADDR == ADDR_W'(i))
          key_d[i*DATA_W +: DATA_W] = merge_bytes(key_q[i*DATA_W +: DATA_W],
                                                  AVL_WRITEDATA, AVL_BYTE_EN);
      end
      for (int i = 0; i < NUM_MSG; i++) begin
        if (AVL_ADDR == ADDR_W'(MSG_BASE + i))
          msg_d[i*DATA_W +: DATA_W] = merge_bytes(msg_q[i*DATA_W +: DATA_W],
                                                  AVL_WRITEDATA, AVL_BYTE_EN);
      end
    end
    if (ctrl_wr && AVL_BYTE_EN[1]) sel_d = AVL_WRITEDATA[15:8];
  end

  // Launch/wait FSM with timeout counter, result capture and status flags.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    done_d  = done_q;
    err_d   = err_q;
    // A timeout in this same cycle still sets the flag below.
    if (clr_req) err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          state_d = ST_LAUNCH;
          done_d  = 1'b0;
        end
      end
      ST_LAUNCH: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion takes priority over a coincident timeout.
        if (ENG_DONE) begin
          res_d   = ENG_RESULT;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Full register-map view shared by bus reads and the export port.
  always_comb begin
    for (int i = 0; i < MAP_WORDS; i++) map_w[i] = '0;
    for (int i = 0; i < NUM_KEY; i++) map_w[i] = key_q[i*DATA_W +: DATA_W];
    for (int i = 0; i < NUM_MSG; i++) map_w[MSG_BASE + i] = msg_q[i*DATA_W +: DATA_W];
    for (int i = 0; i < NUM_OUT; i++) map_w[OUT_BASE + i] = res_q[i*DATA_W +: DATA_W];
    // START/CLR_ERR are self-clearing, so only EXPORT_SEL reads back.
    map_w[CTRL_ADDR] = DATA_W'({sel_q, 8'h00});
    map_w[STAT_ADDR] = DATA_W'({err_q, done_q, busy});
  end

  assign sel_idx = ADDR_W'(sel_q);

  // Registered read data, held between reads; export is a pure mux.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) rdata_d = map_w[AVL_ADDR];
    EXPORT_DATA = '0;
    if ({24'd0, sel_q} < MAP_WORDS) EXPORT_DATA = map_w[sel_idx];
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
      msg_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      msg_q   <= msg_d;
      res_q   <= res_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
    end
  end

  assign AVL_READDATA = rdata_q;
  assign ENG_KEY      = key_q;
  assign ENG_MSG      = msg_q;
  assign ENG_START    = (state_q == ST_LAUNCH);
  assign dbg_state    = state_q;

endmodule
